// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin front end sharing one AES core between two requesters.
// Optional watchdog abort is compiled in with `define AES_ARB_TIMEOUT_EN.
module aes_req_arbiter #(
    parameter int Nk      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [127:0]      req0_data,
    input  logic [32*Nk-1:0]  req0_key,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [127:0]      req1_data,
    input  logic [32*Nk-1:0]  req1_key,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [127:0]      resp_data,
    output logic              resp_id,
    output logic              resp_err,
    output logic              core_load,
    output logic [127:0]      core_pt,
    output logic [32*Nk-1:0]  core_key,
    input  logic [127:0]      core_ct,
    input  logic              core_valid,
    output logic              busy
);

    localparam int KW = 32 * Nk;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic            last;
    logic            grant;
    logic            accept;
    logic            completion;
    logic            timeout_hit;
    logic [127:0]    data_mux;
    logic [KW-1:0]   key_mux;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("aes_req_arbiter: TIMEOUT must be at least 1");
    end

    // A tie goes to whichever requester was not served last.
    assign grant      = req1_valid & (~req0_valid | ~last);
    assign req0_ready = (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = (state == S_IDLE) && req1_valid && grant;
    assign accept     = req0_ready | req1_ready;
    assign completion = (state == S_WAIT) && core_valid;
    assign data_mux   = grant ? req1_data : req0_data;
    assign key_mux    = grant ? req1_key  : req0_key;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            core_load  <= 1'b0;
            core_pt    <= '0;
            core_key   <= '0;
            busy       <= 1'b0;
        end else begin
            core_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        core_pt   <= data_mux;
                        core_key  <= key_mux;
                        resp_id   <= grant;
                        last      <= grant;
                        core_load <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_DRAIN;
                end
                // The core is not reset with us, so a valid level left over from the
                // previous operation must be seen low before a result is trusted.
                S_DRAIN: begin
                    if (timeout_hit) begin
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (!core_valid) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (completion) begin
                        resp_data  <= core_ct;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (timeout_hit) begin
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    assign timeout_hit = ((state == S_DRAIN) || (state == S_WAIT)) &&
                         (wd_cnt == CW'(TIMEOUT - 1));

    // Counts cycles spent waiting on the core; a same-edge completion wins over the abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                wd_cnt <= '0;
            end else if ((state == S_DRAIN) || (state == S_WAIT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (completion) begin
                resp_err <= 1'b0;
            end else if (timeout_hit) begin
                resp_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (state != S_IDLE) |-> !(req0_ready || req1_ready));

    a_load_single : assert property (@(posedge clk) disable iff (!rst_n)
        core_load |=> !core_load);

    a_resp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_id)));

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter: vector table for arbitration plus hand sequences
// for the FIPS-197 round trip, backpressure, stale core valid, reset mid-WAIT and watchdog.
module tb_aes_req_arbiter;

    localparam int NK       = 4;
    localparam int KW       = 32 * NK;
    localparam int TMO      = 16;
    localparam int CORE_LAT = 11;
    // Load sampled at E+1, core valid rises after E+1+LAT, captured one edge later.
    localparam int RESP_LAT = CORE_LAT + 3;

    localparam logic [127:0]  FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [KW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0]  FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0]  STALE_CT = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    localparam logic [127:0]  GOOD_CT  = 128'h0123456789abcdeffedcba9876543210;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [127:0]   req0_data, req1_data;
    logic [KW-1:0]  req0_key, req1_key;
    logic           resp_valid, resp_ready;
    logic [127:0]   resp_data;
    logic           resp_id, resp_err;
    logic           core_load;
    logic [127:0]   core_pt;
    logic [KW-1:0]  core_key;
    logic [127:0]   core_ct;
    logic           core_valid;
    logic           busy;

    logic           auto_en;
    logic           auto_valid   = 1'b0;
    logic [127:0]   auto_ct      = '0;
    logic [127:0]   auto_pending = '0;
    int             auto_cnt     = 0;
    logic           man_valid;
    logic [127:0]   man_ct;

    int checks = 0;
    int errors = 0;
    int ready_viol = 0;

    typedef struct {
        logic v0;
        logic v1;
        logic exp_r0;
        logic exp_r1;
        logic exp_id;
    } vec_t;

    vec_t vecs[10];

    assign core_valid = auto_en ? auto_valid : man_valid;
    assign core_ct    = auto_en ? auto_ct    : man_ct;

    aes_req_arbiter #(.Nk(NK), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_key   (req0_key),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_key   (req1_key),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .core_load  (core_load),
        .core_pt    (core_pt),
        .core_key   (core_key),
        .core_ct    (core_ct),
        .core_valid (core_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the AES core: knows the FIPS-197 answer, otherwise a fixed scramble.
    function automatic logic [127:0] core_model(input logic [127:0] pt, input logic [KW-1:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ key[127:0] ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    // Valid stays high after completion until the next load, like an unreset core.
    always @(posedge clk) begin
        if (core_load) begin
            auto_valid   <= 1'b0;
            auto_ct      <= '0;
            auto_pending <= core_model(core_pt, core_key);
            auto_cnt     <= CORE_LAT;
        end else if (auto_cnt != 0) begin
            auto_cnt <= auto_cnt - 1;
            if (auto_cnt == 1) begin
                auto_valid <= 1'b1;
                auto_ct    <= auto_pending;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready && req1_ready) ready_viol++;
            if (busy && (req0_ready || req1_ready)) ready_viol++;
        end
    end

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, " req0_ready"}, req0_ready, 1'b0);
        check_bit({tag, " req1_ready"}, req1_ready, 1'b0);
        check_bit({tag, " resp_valid"}, resp_valid, 1'b0);
        check_output({tag, " resp_data"}, resp_data, '0);
        check_bit({tag, " resp_id"}, resp_id, 1'b0);
        check_bit({tag, " resp_err"}, resp_err, 1'b0);
        check_bit({tag, " core_load"}, core_load, 1'b0);
        check_output({tag, " core_pt"}, core_pt, '0);
        check_output({tag, " core_key"}, core_key, '0);
        check_bit({tag, " busy"}, busy, 1'b0);
    endtask

    // Called at the first negedge after the accept edge; cycles numbers negedges from there.
    task automatic wait_resp(input int limit, output int cycles);
        cycles = 1;
        while (!resp_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int i);
        logic [127:0]  d0, d1, exp_data;
        logic [KW-1:0] k0, k1;
        int            cycles;
        d0 = {4{32'hA0A0_0000 + 32'(i)}};
        d1 = {4{32'hB1B1_0000 + 32'(i)}};
        k0 = {4{32'h0C0C_0000 + 32'(i)}};
        k1 = {4{32'h1D1D_0000 + 32'(i)}};
        exp_data = v.exp_id ? core_model(d1, k1) : core_model(d0, k0);
        req0_data  = d0;
        req0_key   = k0;
        req1_data  = d1;
        req1_key   = k1;
        req0_valid = v.v0;
        req1_valid = v.v1;
        #1;
        check_bit($sformatf("vec%0d req0_ready", i), req0_ready, v.exp_r0);
        check_bit($sformatf("vec%0d req1_ready", i), req1_ready, v.exp_r1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_bit($sformatf("vec%0d core_load", i), core_load, 1'b1);
        check_output($sformatf("vec%0d core_pt", i), core_pt, v.exp_id ? d1 : d0);
        wait_resp(40, cycles);
        check_count($sformatf("vec%0d latency", i), cycles, RESP_LAT);
        check_bit($sformatf("vec%0d resp_valid", i), resp_valid, 1'b1);
        check_bit($sformatf("vec%0d resp_id", i), resp_id, v.exp_id);
        check_output($sformatf("vec%0d resp_data", i), resp_data, exp_data);
        check_bit($sformatf("vec%0d resp_err", i), resp_err, 1'b0);
        @(negedge clk);
        check_bit($sformatf("vec%0d busy after", i), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int cycles;
        int loads;
        int bad;
        logic [127:0] exp_data;

        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        req0_key   = '0;
        req1_key   = '0;
        resp_ready = 1'b1;
        auto_en    = 1'b1;
        man_valid  = 1'b0;
        man_ct     = '0;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        do_reset();
        check_reset_values("por");

        $display("[TB] single FIPS-197 request");
        req0_data  = FIPS_PT;
        req0_key   = FIPS_KEY;
        req0_valid = 1'b1;
        #1;
        check_bit("fips req0_ready", req0_ready, 1'b1);
        check_bit("fips req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        check_output("fips core_key", core_key, FIPS_KEY);
        check_bit("fips busy", busy, 1'b1);
        loads  = 0;
        cycles = 1;
        while (!resp_valid && cycles < 60) begin
            if (core_load) loads++;
            @(negedge clk);
            cycles++;
        end
        check_count("fips load pulses", loads, 1);
        check_count("fips latency", cycles, RESP_LAT);
        check_bit("fips resp_valid", resp_valid, 1'b1);
        check_output("fips resp_data", resp_data, FIPS_CT);
        check_bit("fips resp_id", resp_id, 1'b0);
        check_bit("fips resp_err", resp_err, 1'b0);
        @(negedge clk);
        check_bit("fips resp_valid drop", resp_valid, 1'b0);

        $display("[TB] arbitration table");
        do_reset();
        check_reset_values("rst2");
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], i);

        $display("[TB] response backpressure");
        resp_ready = 1'b0;
        req1_data  = 128'hcafef00d_cafef00d_12345678_9abcdef0;
        req1_key   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        exp_data   = core_model(req1_data, req1_key);
        req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(40, cycles);
        check_bit("bp resp_valid", resp_valid, 1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!resp_valid || resp_data !== exp_data || resp_id !== 1'b1 || req0_ready || req1_ready || !busy) bad++;
            @(negedge clk);
        end
        check_count("bp stall deviations", bad, 0);
        check_output("bp resp_data", resp_data, exp_data);
        resp_ready = 1'b1;
        @(negedge clk);
        check_bit("bp release resp_valid", resp_valid, 1'b0);
        check_bit("bp release busy", busy, 1'b0);
        check_bit("bp release req0_ready", req0_ready, 1'b1);
        check_bit("bp release req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("[TB] stale core valid");
        @(negedge clk);
        auto_en    = 1'b0;
        man_valid  = 1'b1;
        man_ct     = STALE_CT;
        req0_data  = 128'h11111111_22222222_33333333_44444444;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            if (resp_valid) bad++;
            if (k == 4) man_valid = 1'b0;
            if (k == 5) begin
                man_valid = 1'b1;
                man_ct    = GOOD_CT;
            end
            @(negedge clk);
        end
        check_count("stale early responses", bad, 0);
        check_bit("stale resp_valid", resp_valid, 1'b1);
        check_output("stale resp_data", resp_data, GOOD_CT);
        check_bit("stale resp_id", resp_id, 1'b0);
        man_valid = 1'b0;
        @(negedge clk);

        $display("[TB] reset during WAIT");
        req1_data  = 128'h55555555_66666666_77777777_88888888;
        req1_key   = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("midwait busy", busy, 1'b1);
        check_bit("midwait resp_id", resp_id, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midwait");
        rst_n     = 1'b1;
        man_valid = 1'b1;
        man_ct    = GOOD_CT;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid || core_load || busy) bad++;
        end
        check_count("midwait ghost activity", bad, 0);
        man_valid = 1'b0;
        @(negedge clk);

        $display("[TB] core never completes");
        req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        wait_resp(60, cycles);
        check_count("wd latency", cycles, TMO + 2);
        check_bit("wd resp_valid", resp_valid, 1'b1);
        check_bit("wd resp_err", resp_err, 1'b1);
        check_output("wd resp_data", resp_data, '0);
        check_bit("wd resp_id", resp_id, 1'b1);
        @(negedge clk);
        check_bit("wd busy after", busy, 1'b0);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy || resp_valid) bad++;
            @(negedge clk);
        end
        check_count("hang deviations", bad, 0);
        check_bit("hang busy", busy, 1'b1);
        do_reset();
        check_bit("hang busy after reset", busy, 1'b0);
`endif

        check_count("ready exclusivity violations", ready_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
